mprj_gpio_ctrl: RTL and testbench
=================================

// Module: mprj_gpio_ctrl
// PURPOSE
//  Wishbone-mapped GPIO controller in the Caravel user-project area; the management core drives the user I/O pads.
//  Firmware sets per-pin output-enable and output value; pad inputs are synchronised and readable.
//  Sits between the management Wishbone bus (user window) and the io_in/io_out/io_oeb pad bus.
// PARAMETERS
//  BASE_ADR  32'h3000_0000  base of the register window; decode on wbs_adr_i[31:8] == BASE_ADR[31:8]
//  NUM_IO    38             number of user pads (bits above NUM_IO-1 are read-as-zero/write-ignored)
// PORTS
//  wb_clk_i   in   1   single clock; all logic on rising edge
//  wb_rst_i   in   1   reset, synchronous, active-high
//  wbs_stb_i  in   1   Wishbone strobe
//  wbs_cyc_i  in   1   Wishbone cycle
//  wbs_we_i   in   1   1 = write, 0 = read
//  wbs_sel_i  in   4   byte lanes for writes
//  wbs_adr_i  in   32  byte address
//  wbs_dat_i  in   32  write data
//  wbs_ack_o  out  1   transfer acknowledge
//  wbs_dat_o  out  32  read data
//  io_in      in   38  pad input values
//  io_out     out  38  pad output values
//  io_oeb     out  38  pad output-enable, active-low (1 = input)
// BEHAVIOUR
//  Registers (offset from BASE_ADR, 32-bit, little-endian byte lanes):
//   0x00 OUT_LO  RW  io_out[31:0]        0x04 OUT_HI  RW  io_out[37:32] in bits[5:0]
//   0x08 OE_LO   RW  1=drive pin[31:0]   0x0C OE_HI   RW  bits[5:0] -> pins[37:32]
//   0x10 IN_LO   RO  sync io_in[31:0]    0x14 IN_HI   RO  sync io_in[37:32]
//   0x18 SET_LO  WO  OUT_LO |= data      0x1C CLR_LO  WO  OUT_LO &= ~data (both read 0)
//  io_out = {OUT_HI[5:0],OUT_LO}; io_oeb = ~{OE_HI[5:0],OE_LO}; combinational from registers.
//  Reset: OUT=0, OE=0 -> io_out=0, io_oeb=all 1; wbs_ack_o=0; wbs_dat_o=0; sync flops=0.
//  Handshake: hit = cyc&stb&addr-in-window&!ack. ack asserted exactly one cycle after hit, for one cycle;
//   back-to-back transfers thus take 2 cycles each. Out-of-window addresses: no ack, no effect.
//  Writes: commit on the hit cycle edge, honouring wbs_sel_i per byte; pins change 1 cycle after hit.
//  Reads: wbs_dat_o registered, valid with ack; 0 when ack low; unmapped in-window offsets ack, read 0, ignore writes.
//  Unused high bits of OUT_HI/OE_HI read 0, writes ignored.
//  io_in passes a 2-flop synchroniser; IN_* reflect pad value 2 cycles after change.
//  SET/CLR honour sel per byte; write to OUT_LO and SET/CLR never coincide (single-port bus).
//  wb_rst_i mid-transfer: registers return to reset values, pending ack dropped, transfer not completed.
// TESTING
//  reset, then read all offsets -> 0x00..0x0C read 0, io_oeb=38'h3F_FFFF_FFFF, io_out=0.
//  write OE_LO=FFFFFFFF, OUT_LO=12345678 -> io_out[31:0]=32'h12345678, io_oeb[31:0]=0, ack 1 cycle after stb.
//  write OUT_LO=0 sel=4'b0011 data=FFFFFFFF after above -> OUT_LO=1234FFFF; then CLR_LO=0000FF00 -> 123400FF.
//  OE_HI=3F, OUT_HI=2A -> io_out[37:32]=6'h2A, io_oeb[37:32]=0; OUT_HI readback 0000002A.
//  drive io_in=38'h15_A5A5_5A5A -> IN_LO=A5A55A5A, IN_HI=15 no earlier than 2 cycles later.
//  access BASE_ADR+0x100 -> no ack; offset 0x40 -> ack, read 0; reset mid-write -> no ack, regs zero.

Source files
------------

// File: rtl/mprj_gpio_ctrl.sv
// Wishbone-mapped GPIO block: per-pin output value/enable registers driving the
// user pad bus, plus a two-flop synchronised view of the pad inputs.
module mprj_gpio_ctrl #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          NUM_IO   = 38
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb
);

  localparam int HI_W = NUM_IO - 32;

  logic [31:0]       out_lo, oe_lo;
  logic [HI_W-1:0]   out_hi, oe_hi;
  logic [NUM_IO-1:0] sync1, sync2;
  logic [31:0]       lane_mask;
  logic [31:0]       rd_data;
  logic              hit;

  assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  // The !ack term keeps a held strobe from being accepted twice.
  assign hit = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
               (wbs_adr_i[31:8] == BASE_ADR[31:8]);

  function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [HI_W-1:0] merge_hi(input logic [HI_W-1:0] old_v,
                                               input logic [31:0]     new_v,
                                               input logic [31:0]     mask);
    return (old_v & ~mask[HI_W-1:0]) | (new_v[HI_W-1:0] & mask[HI_W-1:0]);
  endfunction

  always_comb begin
    rd_data = 32'h0;
    case (wbs_adr_i[7:0])
      8'h00: rd_data = out_lo;
      8'h04: rd_data = {{(32-HI_W){1'b0}}, out_hi};
      8'h08: rd_data = oe_lo;
      8'h0C: rd_data = {{(32-HI_W){1'b0}}, oe_hi};
      8'h10: rd_data = sync2[31:0];
      8'h14: rd_data = {{(64-NUM_IO){1'b0}}, sync2[NUM_IO-1:32]};
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_lo    <= '0;
      out_hi    <= '0;
      oe_lo     <= '0;
      oe_hi     <= '0;
      sync1     <= '0;
      sync2     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      sync1     <= io_in;
      sync2     <= sync1;
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit && !wbs_we_i) ? rd_data : 32'h0;
      if (hit && wbs_we_i) begin
        case (wbs_adr_i[7:0])
          8'h00: out_lo <= merge32(out_lo, wbs_dat_i, lane_mask);
          8'h04: out_hi <= merge_hi(out_hi, wbs_dat_i, lane_mask);
          8'h08: oe_lo  <= merge32(oe_lo, wbs_dat_i, lane_mask);
          8'h0C: oe_hi  <= merge_hi(oe_hi, wbs_dat_i, lane_mask);
          8'h18: out_lo <= out_lo | (wbs_dat_i & lane_mask);
          8'h1C: out_lo <= out_lo & ~(wbs_dat_i & lane_mask);
          default: ;
        endcase
      end
    end
  end

  assign io_out = {out_hi, out_lo};
  assign io_oeb = ~{oe_hi, oe_lo};

endmodule

// File: tb/tb_mprj_gpio_ctrl.sv
// Directed bench for mprj_gpio_ctrl: register access, byte lanes, set/clear,
// input synchroniser latency, address window and mid-transfer reset.
module tb_mprj_gpio_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] io_in, io_out, io_oeb;

  int errors = 0;
  int checks = 0;

  mprj_gpio_ctrl dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer: strobe at negedge, ack must be high right after the next
  // edge and gone one edge later. Returns the data sampled with ack.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] q);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    chk("ack_rise", {63'h0, ack}, 64'h1);
    q = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_fall", {63'h0, ack}, 64'h0);
    chk("dat_idle", {32'h0, rdat}, 64'h0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    xfer(1'b1, BASE + off, d, s, q);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] q;
    xfer(1'b0, BASE + off, 32'h0, 4'h0, q);
    chk(tag, {32'h0, q}, {32'h0, exp});
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; wdat = 32'h0; io_in = 38'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_io_out", {26'h0, io_out}, 64'h0);
    chk("rst_io_oeb", {26'h0, io_oeb}, {26'h0, 38'h3F_FFFF_FFFF});
    chk("rst_ack", {63'h0, ack}, 64'h0);
    chk("rst_dat", {32'h0, rdat}, 64'h0);
    @(negedge clk); rst = 1'b0;

    rd_chk("rd_out_lo0", 32'h00, 32'h0);
    rd_chk("rd_out_hi0", 32'h04, 32'h0);
    rd_chk("rd_oe_lo0",  32'h08, 32'h0);
    rd_chk("rd_oe_hi0",  32'h0C, 32'h0);

    wr(32'h08, 32'hFFFF_FFFF, 4'hF);
    wr(32'h00, 32'h1234_5678, 4'hF);
    chk("io_out_lo", {32'h0, io_out[31:0]}, 64'h1234_5678);
    chk("io_oeb_lo", {32'h0, io_oeb[31:0]}, 64'h0);
    chk("io_oeb_hi_idle", {58'h0, io_oeb[37:32]}, 64'h3F);

    wr(32'h00, 32'hFFFF_FFFF, 4'b0011);
    rd_chk("rd_sel_lanes", 32'h00, 32'h1234_FFFF);
    wr(32'h1C, 32'h0000_FF00, 4'hF);
    rd_chk("rd_after_clr", 32'h00, 32'h1234_00FF);
    wr(32'h18, 32'h0F00_F000, 4'b1000);
    rd_chk("rd_after_set", 32'h00, 32'h1F34_00FF);
    rd_chk("rd_set_wo", 32'h18, 32'h0);
    rd_chk("rd_clr_wo", 32'h1C, 32'h0);

    wr(32'h0C, 32'h0000_003F, 4'hF);
    wr(32'h04, 32'h0000_002A, 4'hF);
    chk("io_out_hi", {58'h0, io_out[37:32]}, 64'h2A);
    chk("io_oeb_hi", {58'h0, io_oeb[37:32]}, 64'h0);
    rd_chk("rd_out_hi", 32'h04, 32'h0000_002A);
    wr(32'h04, 32'hFFFF_FFD5, 4'hF);
    rd_chk("rd_out_hi_mask", 32'h04, 32'h0000_0015);
    rd_chk("rd_oe_hi", 32'h0C, 32'h0000_003F);

    // Pad change just after an edge: a read hitting on the second edge
    // still sees the old value; a later one sees the new value.
    io_in = 38'h15_A5A5_5A5A;
    @(posedge clk); #1;
    rd_chk("rd_in_early", 32'h10, 32'h0);
    rd_chk("rd_in_lo", 32'h10, 32'hA5A5_5A5A);
    rd_chk("rd_in_hi", 32'h14, 32'h0000_0015);

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h100; wdat = 32'h0; sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("oow_no_ack", {63'h0, ack}, 64'h0);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("oow_no_write", {32'h0, io_out[31:0]}, 64'h1F34_00FF);

    rd_chk("rd_unmapped", 32'h40, 32'h0);
    wr(32'h40, 32'h0, 4'hF);
    chk("unmapped_no_write", {26'h0, io_out}, {26'h0, 38'h15_1F34_00FF});

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'hDEAD_BEEF; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack", {63'h0, ack}, 64'h0);
    chk("rst_mid_out", {26'h0, io_out}, 64'h0);
    chk("rst_mid_oeb", {26'h0, io_oeb}, {26'h0, 38'h3F_FFFF_FFFF});
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ack", {63'h0, ack}, 64'h0);
    rd_chk("post_rst_out_lo", 32'h00, 32'h0);
    rd_chk("post_rst_oe_lo", 32'h08, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
